fan_output_collector: RTL and testbench

- Sits directly downstream of the forwarding adder network output stage.
- Each cycle it accepts a sparse NUM_PES-wide group of completed partial sums (per-PE valid mask plus data bus), compacts the valid lanes in ascending PE order, and buffers them in a circular FIFO.
- It drains one psum per cycle to the output buffer writer over a valid/ready handshake.
- It reports almost-full back-pressure so the controller can stall issue into the reduction network.

---
 rtl/fan_output_collector.sv | 154 +++++++++++++++
 tb/tb_fan_output_collector.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fan_output_collector.sv
// -----------------------------------------------------------------------------
// fan_output_collector
//
// Collects sparse groups of completed partial sums from the forwarding adder
// network output stage. Each cycle the valid lanes of the incoming group are
// compacted in ascending lane order and written into a circular FIFO. The FIFO
// drains one psum per cycle towards the output buffer writer.
//
// Optional feature (macro FAN_COLLECT_TAG_EN):
//   defined   : the source lane index is stored with every entry and driven on
//               o_idx.
//   undefined : no index storage is built and o_idx is tied to 0.
//
// Handshake: the output side is a strict valid/ready pair. o_valid depends
// only on registered state and, once high, stays high with o_data/o_idx stable
// until the cycle in which i_ready is also high. A transfer (pop) happens on
// every rising edge where o_valid && i_ready. i_ready while empty is ignored.
// The input side has no ready; the controller watches o_full instead.
//
// Ports:
//   clk         clock
//   rst         synchronous, active-high reset
//   i_valid     per-lane completed-psum mask (bit k qualifies lane k)
//   i_data_bus  lane k at bits [k*DATA_TYPE +: DATA_TYPE]
//   o_full      almost-full: fewer than NUM_PES free entries
//   o_valid     head entry available
//   i_ready     downstream accepts the head this cycle
//   o_data      head psum (0 while empty)
//   o_idx       source lane of the head psum (0 while empty or untagged)
//   o_count     current occupancy
//   o_total     psums accepted since reset, wraps modulo 2^16
//   o_overflow  sticky: a group was dropped for lack of space
// -----------------------------------------------------------------------------
module fan_output_collector #(
  parameter int DATA_TYPE  = 32,
  parameter int NUM_PES    = 4,
  parameter int LOG2_PES   = 2,
  parameter int FIFO_DEPTH = 16,
  parameter int LOG2_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_PES-1:0]            i_valid,
  input  logic [NUM_PES*DATA_TYPE-1:0]  i_data_bus,
  output logic                          o_full,
  output logic                          o_valid,
  input  logic                          i_ready,
  output logic [DATA_TYPE-1:0]          o_data,
  output logic [LOG2_PES-1:0]           o_idx,
  output logic [LOG2_DEPTH:0]           o_count,
  output logic [15:0]                   o_total,
  output logic                          o_overflow
);

  localparam logic [LOG2_DEPTH:0] DEPTH_C = (LOG2_DEPTH+1)'(FIFO_DEPTH);
  localparam logic [LOG2_DEPTH:0] PES_C   = (LOG2_DEPTH+1)'(NUM_PES);

  // Storage
  logic [DATA_TYPE-1:0] mem_data [FIFO_DEPTH];
`ifdef FAN_COLLECT_TAG_EN
  logic [LOG2_PES-1:0]  mem_idx  [FIFO_DEPTH];
`endif

  // Registered state
  logic [LOG2_DEPTH-1:0] wptr;
  logic [LOG2_DEPTH-1:0] rptr;
  logic [LOG2_DEPTH:0]   count;
  logic [15:0]           total;
  logic                  overflow;

  // Per-cycle control
  logic [LOG2_PES:0]     n;
  logic [LOG2_PES:0]     offset [NUM_PES];
  logic [LOG2_DEPTH:0]   n_ext;
  logic [LOG2_DEPTH:0]   n_acc;
  logic [LOG2_DEPTH:0]   free;
  logic                  accept;
  logic                  drop;
  logic                  pop;

  // Exclusive prefix popcount: offset[k] is the number of valid lanes below
  // lane k, i.e. the slot distance from wptr where lane k lands.
  always_comb begin
    n = '0;
    for (int k = 0; k < NUM_PES; k++) begin
      offset[k] = n;
      n         = n + (LOG2_PES+1)'(i_valid[k]);
    end
  end

  // Free space comes from the registered count only, so a same-cycle pop
  // never makes room for the group arriving in that cycle.
  always_comb begin
    free   = DEPTH_C - count;
    n_ext  = (LOG2_DEPTH+1)'(n);
    accept = (n != '0) && (n_ext <= free);
    drop   = (n_ext > free);
    n_acc  = accept ? n_ext : '0;
    pop    = (count != '0) && i_ready;
  end

  // Compacted write: all valid lanes land in consecutive slots, wrapping
  // naturally through the pointer width. Groups are all-or-nothing.
  always_ff @(posedge clk) begin
    if (!rst && accept) begin
      for (int k = 0; k < NUM_PES; k++) begin
        if (i_valid[k]) begin
          mem_data[wptr + LOG2_DEPTH'(offset[k])] <= i_data_bus[k*DATA_TYPE +: DATA_TYPE];
`ifdef FAN_COLLECT_TAG_EN
          mem_idx[wptr + LOG2_DEPTH'(offset[k])]  <= LOG2_PES'(k);
`endif
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      total    <= '0;
      overflow <= 1'b0;
    end else begin
      if (accept) begin
        wptr <= wptr + LOG2_DEPTH'(n);
      end
      if (pop) begin
        rptr <= rptr + LOG2_DEPTH'(1);
      end
      count <= count + n_acc - (LOG2_DEPTH+1)'(pop);
      total <= total + 16'(n_acc);
      if (drop) begin
        overflow <= 1'b1;
      end
    end
  end

  // Show-ahead output straight from storage; forced to 0 while empty.
  always_comb begin
    o_valid    = (count != '0);
    o_full     = (free < PES_C);
    o_count    = count;
    o_total    = total;
    o_overflow = overflow;
    o_data     = o_valid ? mem_data[rptr] : '0;
`ifdef FAN_COLLECT_TAG_EN
    o_idx      = o_valid ? mem_idx[rptr] : '0;
`else
    o_idx      = '0;
`endif
  end

endmodule

// File: tb/tb_fan_output_collector.sv
// -----------------------------------------------------------------------------
// tb_fan_output_collector
//
// Directed table of vectors for reset, compaction, back-pressure, overflow and
// simultaneous push/pop, a reset-with-traffic sequence, then randomized groups
// checked against a queue-based reference model.
// -----------------------------------------------------------------------------
module tb_fan_output_collector;

  localparam int DW = 32;
  localparam int NP = 4;
  localparam int LP = 2;
  localparam int FD = 16;
  localparam int LD = 4;
  localparam int W  = LP + DW;
`ifdef FAN_COLLECT_TAG_EN
  localparam bit TAG_EN = 1'b1;
`else
  localparam bit TAG_EN = 1'b0;
`endif

  logic              clk;
  logic              rst;
  logic [NP-1:0]     i_valid;
  logic [NP*DW-1:0]  i_data_bus;
  logic              o_full;
  logic              o_valid;
  logic              i_ready;
  logic [DW-1:0]     o_data;
  logic [LP-1:0]     o_idx;
  logic [LD:0]       o_count;
  logic [15:0]       o_total;
  logic              o_overflow;

  fan_output_collector #(
    .DATA_TYPE(DW), .NUM_PES(NP), .LOG2_PES(LP), .FIFO_DEPTH(FD), .LOG2_DEPTH(LD)
  ) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_data_bus(i_data_bus),
    .o_full(o_full), .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data),
    .o_idx(o_idx), .o_count(o_count), .o_total(o_total), .o_overflow(o_overflow)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int tests = 0;
  int fails = 0;
  logic [W-1:0] exp_q[$];
  logic [15:0]  m_total;
  bit           m_ovf;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_idx(int lane);
    return TAG_EN ? 32'(lane & 3) : 32'd0;
  endfunction

  function automatic logic [NP*DW-1:0] mk_bus(logic [31:0] base);
    logic [NP*DW-1:0] b;
    for (int k = 0; k < NP; k++) b[k*DW +: DW] = base + 32'(k);
    return b;
  endfunction

  // ---------------- driver tasks ----------------
  // Inputs change 1 time unit after a rising edge; outputs are sampled there too.
  task automatic cycle(logic [NP-1:0] v, logic [NP*DW-1:0] bus, logic rdy);
    i_valid    = v;
    i_data_bus = bus;
    i_ready    = rdy;
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  // Abstract view: the FIFO is a queue of {lane, data}; a group goes in whole
  // or not at all, judged against the space before this cycle's pop.
  task automatic model_step(logic [NP-1:0] v, logic [NP*DW-1:0] bus, logic rdy);
    int free_sp = FD - exp_q.size();
    int n = $countones(v);
    if (exp_q.size() > 0 && rdy) void'(exp_q.pop_front());
    if (n > 0 && n <= free_sp) begin
      for (int k = 0; k < NP; k++)
        if (v[k]) exp_q.push_back({LP'(k), bus[k*DW +: DW]});
      m_total = m_total + 16'(n);
    end else if (n > free_sp) begin
      m_ovf = 1'b1;
    end
  endtask

  function automatic bit model_full();
    return (FD - exp_q.size()) < NP;
  endfunction

  task automatic check_model(string tag);
    logic [W-1:0] head;
    head = (exp_q.size() > 0) ? exp_q[0] : '0;
    chk({tag, ".count"}, 32'(o_count), 32'(exp_q.size()));
    chk({tag, ".valid"}, 32'(o_valid), 32'(exp_q.size() != 0));
    chk({tag, ".full"},  32'(o_full),  32'(model_full()));
    chk({tag, ".data"},  o_data,       head[DW-1:0]);
    chk({tag, ".idx"},   32'(o_idx),   exp_idx(int'(head[W-1:DW])));
    chk({tag, ".total"}, 32'(o_total), 32'(m_total));
    chk({tag, ".ovf"},   32'(o_overflow), 32'(m_ovf));
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [NP-1:0]    v;
    logic [NP*DW-1:0] bus;
    logic             rdy;
    int               cnt;
    bit               full;
    bit               vld;
    logic [31:0]      data;
    int               lane;
    int               total;
    bit               ovf;
  } vec_t;

  vec_t tbl[15];

  function automatic vec_t mkv(logic [NP-1:0] v, logic [NP*DW-1:0] bus, logic rdy,
                               int cnt, bit full, bit vld, logic [31:0] data,
                               int lane, int total, bit ovf);
    vec_t r;
    r.v = v; r.bus = bus; r.rdy = rdy; r.cnt = cnt; r.full = full; r.vld = vld;
    r.data = data; r.lane = lane; r.total = total; r.ovf = ovf;
    return r;
  endfunction

  initial begin
    logic [31:0] drain_exp [15];
    logic [NP-1:0] v;
    logic [NP*DW-1:0] bus;
    logic rdy;
    int groups;
    int c;

    // compaction of sparse 1010 group, then drain to empty
    tbl[0]  = mkv(4'b1010, {32'h33, 32'hCC, 32'h11, 32'hAA}, 1'b1, 2, 0, 1, 32'h11, 1, 2, 0);
    tbl[1]  = mkv(4'b0000, '0, 1'b1, 1, 0, 1, 32'h33, 3, 2, 0);
    tbl[2]  = mkv(4'b0000, '0, 1'b1, 0, 0, 0, 32'h0, 0, 2, 0);
    // back-pressure: fill to 16, almost-full at exactly full
    tbl[3]  = mkv(4'b1111, mk_bus(32'h100), 1'b0, 4,  0, 1, 32'h100, 0, 6, 0);
    tbl[4]  = mkv(4'b1111, mk_bus(32'h200), 1'b0, 8,  0, 1, 32'h100, 0, 10, 0);
    tbl[5]  = mkv(4'b1111, mk_bus(32'h300), 1'b0, 12, 0, 1, 32'h100, 0, 14, 0);
    tbl[6]  = mkv(4'b1111, mk_bus(32'h400), 1'b0, 16, 1, 1, 32'h100, 0, 18, 0);
    tbl[7]  = mkv(4'b0000, '0, 1'b1, 15, 1, 1, 32'h101, 1, 18, 0);
    tbl[8]  = mkv(4'b0000, '0, 1'b1, 14, 1, 1, 32'h102, 2, 18, 0);
    tbl[9]  = mkv(4'b0000, '0, 1'b1, 13, 1, 1, 32'h103, 3, 18, 0);
    tbl[10] = mkv(4'b0000, '0, 1'b1, 12, 0, 1, 32'h200, 0, 18, 0);
    // overflow at count 14: group of 3 dropped whole
    tbl[11] = mkv(4'b0011, mk_bus(32'h500), 1'b0, 14, 1, 1, 32'h200, 0, 20, 0);
    tbl[12] = mkv(4'b0111, mk_bus(32'h600), 1'b0, 14, 1, 1, 32'h200, 0, 20, 1);
    // simultaneous push and pop at count 13 with exactly enough room
    tbl[13] = mkv(4'b0000, '0, 1'b1, 13, 1, 1, 32'h201, 1, 20, 1);
    tbl[14] = mkv(4'b1101, mk_bus(32'h700), 1'b1, 15, 1, 1, 32'h202, 2, 23, 1);

    drain_exp = '{32'h202, 32'h203, 32'h300, 32'h301, 32'h302, 32'h303,
                  32'h400, 32'h401, 32'h402, 32'h403, 32'h500, 32'h501,
                  32'h700, 32'h702, 32'h703};

    // reset
    rst = 1'b1;
    cycle('0, '0, 1'b0);
    cycle('0, '0, 1'b0);
    rst = 1'b0;
    chk("rst.valid", 32'(o_valid), 0);
    chk("rst.count", 32'(o_count), 0);
    chk("rst.full",  32'(o_full), 0);
    chk("rst.total", 32'(o_total), 0);
    chk("rst.ovf",   32'(o_overflow), 0);
    chk("rst.data",  o_data, 0);

    for (int i = 0; i < 15; i++) begin
      cycle(tbl[i].v, tbl[i].bus, tbl[i].rdy);
      chk($sformatf("tbl%0d.count", i), 32'(o_count), 32'(tbl[i].cnt));
      chk($sformatf("tbl%0d.full", i),  32'(o_full), 32'(tbl[i].full));
      chk($sformatf("tbl%0d.valid", i), 32'(o_valid), 32'(tbl[i].vld));
      chk($sformatf("tbl%0d.data", i),  o_data, tbl[i].data);
      chk($sformatf("tbl%0d.idx", i),   32'(o_idx), exp_idx(tbl[i].lane));
      chk($sformatf("tbl%0d.total", i), 32'(o_total), 32'(tbl[i].total));
      chk($sformatf("tbl%0d.ovf", i),   32'(o_overflow), 32'(tbl[i].ovf));
    end

    // drain the remaining 15 entries in order; overflow must stay sticky
    for (int i = 0; i < 15; i++) begin
      chk($sformatf("drain%0d.data", i), o_data, drain_exp[i]);
      chk($sformatf("drain%0d.idx", i), 32'(o_idx), exp_idx(int'(drain_exp[i][1:0])));
      cycle('0, '0, 1'b1);
    end
    chk("drain.count", 32'(o_count), 0);
    chk("drain.valid", 32'(o_valid), 0);
    chk("drain.data",  o_data, 0);
    chk("drain.ovf",   32'(o_overflow), 1);
    chk("drain.total", 32'(o_total), 23);

    // reset with prior traffic; the group shown during reset is discarded
    cycle(4'b1111, mk_bus(32'h800), 1'b0);
    rst = 1'b1;
    cycle(4'b1111, mk_bus(32'h900), 1'b0);
    rst = 1'b0;
    i_valid = '0;
    chk("rst2.valid", 32'(o_valid), 0);
    chk("rst2.count", 32'(o_count), 0);
    chk("rst2.total", 32'(o_total), 0);
    chk("rst2.ovf",   32'(o_overflow), 0);
    chk("rst2.full",  32'(o_full), 0);
    cycle('0, '0, 1'b0);
    chk("rst2.idle_count", 32'(o_count), 0);
    chk("rst2.idle_total", 32'(o_total), 0);

    // randomized groups against the reference model
    exp_q.delete();
    m_total = '0;
    m_ovf   = 1'b0;
    groups  = 0;
    for (c = 0; c < 2000 && (groups < 40 || exp_q.size() != 0); c++) begin
      if (groups < 40 && !model_full() && $urandom_range(0, 3) != 0) begin
        v = NP'($urandom_range(1, 15));
        groups++;
      end else begin
        v = '0;
      end
      bus = {$urandom, $urandom, $urandom, $urandom};
      rdy = (groups < 40) ? 1'($urandom_range(0, 1)) : 1'b1;
      model_step(v, bus, rdy);
      cycle(v, bus, rdy);
      check_model($sformatf("rnd%0d", c));
    end
    chk("rnd.groups_done", 32'(groups), 40);
    chk("rnd.drained", 32'(o_count), 0);
    chk("rnd.no_drop", 32'(o_overflow), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
